pipe_ctrl: RTL and testbench

//  Pipeline sequencer between the execute stage and the front-end registers (pc_reg, if_id, id_ex).

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_ctrl_sat_counter.sv | 32 +++
 rtl/pipe_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: controller states,
// the front-end control bundle and its idle value.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_HOLD_JMP = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] ZeroAddr     = 32'h0000_0000;
    localparam logic        JumpEnable   = 1'b1;
    localparam logic        JumpDisable  = 1'b0;
    localparam logic        StallEnable  = 1'b1;
    localparam logic        StallDisable = 1'b0;
    localparam int          FlushCntW    = 3;

    typedef struct packed {
        logic        jumpEn;
        logic [31:0] jumpAddr;
        logic        stallPc;
        logic        stallIfId;
        logic        stallIdEx;
        logic        flushIfId;
        logic        flushIdEx;
    } ctrl_out_t;

    localparam ctrl_out_t CtrlIdle = '{
        jumpEn:    JumpDisable,
        jumpAddr:  ZeroAddr,
        stallPc:   StallDisable,
        stallIfId: StallDisable,
        stallIdEx: StallDisable,
        flushIfId: 1'b0,
        flushIdEx: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_if.sv
// Execute-side requests and front-end control outputs of the pipeline sequencer.
// The slave modport is the sequencer itself; master is whoever drives the requests.
interface pipe_ctrl_if;

    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i;
    logic        hold_bus_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        stall_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;

    modport master (
        output jump_en_i, jump_addr_i, hold_ex_i, hold_bus_i,
        input  jump_en_o, jump_addr_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
               flush_if_id_o, flush_id_ex_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, hold_ex_i, hold_bus_i,
        output jump_en_o, jump_addr_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
               flush_if_id_o, flush_id_ex_o
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the sequencer's performance counters;
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns execute redirects/holds and bus stalls into PC redirect,
// per-stage stall/flush controls, with a hold watchdog and saturating perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int HOLD_MAX     = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       bus,
    output logic             hold_timeout_o,
    output logic [CNT_W-1:0] jump_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [FlushCntW-1:0] FlushInit = FlushCntW'(FLUSH_CYCLES - 1);
    localparam int                   HoldW     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HoldW-1:0]     HoldLast  = HoldW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    ctrl_state_e          state_q, state_d;
    logic [FlushCntW-1:0] flushCnt_q, flushCnt_d;
    logic [31:0]          pendAddr_q, pendAddr_d;
    logic [HoldW-1:0]     holdRun_q, holdRun_d;
    logic                 holdTimeout_q, holdTimeout_d;

    ctrl_out_t   ctrlOut;
    logic        doRedirect;
    logic [31:0] redirAddr;
    logic        held;
    logic        anyStall;
    logic [CNT_W-1:0] jumpCnt;
    logic [CNT_W-1:0] stallCnt;

    // Bus stall outranks any jump; a jump seen under bus stall is parked until the bus frees.
    always_comb begin
        ctrlOut    = CtrlIdle;
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        pendAddr_d = pendAddr_q;
        doRedirect = 1'b0;
        redirAddr  = ZeroAddr;

        case (state_q)
            CTRL_RUN: begin
                if (bus.hold_bus_i) begin
                    ctrlOut.stallPc   = StallEnable;
                    ctrlOut.stallIfId = StallEnable;
                    ctrlOut.stallIdEx = StallEnable;
                    if (bus.jump_en_i) begin
                        pendAddr_d = bus.jump_addr_i;
                        state_d    = CTRL_HOLD_JMP;
                    end
                end else if (bus.jump_en_i) begin
                    doRedirect = 1'b1;
                    redirAddr  = bus.jump_addr_i;
                end else if (bus.hold_ex_i) begin
                    ctrlOut.stallPc   = StallEnable;
                    ctrlOut.stallIfId = StallEnable;
                    ctrlOut.flushIdEx = 1'b1;
                end
            end
            CTRL_FLUSH: begin
                ctrlOut.flushIfId = 1'b1;
                ctrlOut.flushIdEx = 1'b1;
                if (bus.hold_bus_i) begin
                    ctrlOut.stallPc = StallEnable;
                end
                if (flushCnt_q <= FlushCntW'(1)) begin
                    state_d    = CTRL_RUN;
                    flushCnt_d = '0;
                end else begin
                    flushCnt_d = flushCnt_q - FlushCntW'(1);
                end
            end
            CTRL_HOLD_JMP: begin
                if (bus.hold_bus_i) begin
                    ctrlOut.stallPc   = StallEnable;
                    ctrlOut.stallIfId = StallEnable;
                    ctrlOut.stallIdEx = StallEnable;
                end else begin
                    doRedirect = 1'b1;
                    redirAddr  = pendAddr_q;
                end
            end
            default: begin
                state_d = CTRL_RUN;
            end
        endcase

        if (doRedirect) begin
            ctrlOut.jumpEn    = JumpEnable;
            ctrlOut.jumpAddr  = redirAddr;
            ctrlOut.flushIfId = 1'b1;
            ctrlOut.flushIdEx = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d    = CTRL_FLUSH;
                flushCnt_d = FlushInit;
            end else begin
                state_d    = CTRL_RUN;
            end
        end

        if (rst) begin
            ctrlOut = CtrlIdle;
        end
    end

    assign held = bus.hold_ex_i | bus.hold_bus_i;

    always_comb begin
        holdRun_d     = '0;
        holdTimeout_d = holdTimeout_q;
        if (held) begin
            holdRun_d = (holdRun_q == HoldLast) ? holdRun_q : holdRun_q + HoldW'(1);
            if ((HOLD_MAX != 0) && (holdRun_q == HoldLast)) begin
                holdTimeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CTRL_RUN;
            flushCnt_q    <= '0;
            pendAddr_q    <= ZeroAddr;
            holdRun_q     <= '0;
            holdTimeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flushCnt_q    <= flushCnt_d;
            pendAddr_q    <= pendAddr_d;
            holdRun_q     <= holdRun_d;
            holdTimeout_q <= holdTimeout_d;
        end
    end

    assign anyStall = ctrlOut.stallPc | ctrlOut.stallIfId | ctrlOut.stallIdEx;

    sat_counter #(.W(CNT_W)) u_jump_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ctrlOut.jumpEn),
        .cnt_o (jumpCnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (anyStall),
        .cnt_o (stallCnt)
    );

    assign bus.jump_en_o     = ctrlOut.jumpEn;
    assign bus.jump_addr_o   = ctrlOut.jumpAddr;
    assign bus.stall_pc_o    = ctrlOut.stallPc;
    assign bus.stall_if_id_o = ctrlOut.stallIfId;
    assign bus.stall_id_ex_o = ctrlOut.stallIdEx;
    assign bus.flush_if_id_o = ctrlOut.flushIfId;
    assign bus.flush_id_ex_o = ctrlOut.flushIdEx;

    assign hold_timeout_o = rst ? 1'b0 : holdTimeout_q;
    assign jump_cnt_o     = rst ? '0 : jumpCnt;
    assign stall_cnt_o    = rst ? '0 : stallCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (FLUSH_CYCLES=3, HOLD_MAX=8, CNT_W=4):
// each step queues the expected front-end controls and compares them mid-cycle.
module tb_pipe_ctrl;

    localparam int CntW = 4;

    logic            clk;
    logic            rst;
    logic            holdTimeout;
    logic [CntW-1:0] jumpCnt;
    logic [CntW-1:0] stallCnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [37:0] vec;
    } exp_t;

    exp_t expQ[$];

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .FLUSH_CYCLES (3),
        .HOLD_MAX     (8),
        .CNT_W        (CntW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .hold_timeout_o (holdTimeout),
        .jump_cnt_o     (jumpCnt),
        .stall_cnt_o    (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t        e;
        logic [37:0] obs;
        obs = {bus.jump_en_o, bus.jump_addr_o, bus.stall_pc_o, bus.stall_if_id_o,
               bus.stall_id_ex_o, bus.flush_if_id_o, bus.flush_id_ex_o};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = expQ.pop_front();
            assert (obs === e.vec) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
            end
        end
    endtask

    // Expected vector order: jump_en, jump_addr, stall {pc,if_id,id_ex}, flush {if_id,id_ex}.
    task automatic applyStimulus(input string tag, input logic r, input logic je,
                                 input logic [31:0] ja, input logic hx, input logic hb,
                                 input logic eJe, input logic [31:0] eJa,
                                 input logic [2:0] eSt, input logic [1:0] eFl);
        @(posedge clk);
        #1;
        rst             = r;
        bus.jump_en_i   = je;
        bus.jump_addr_i = ja;
        bus.hold_ex_i   = hx;
        bus.hold_bus_i  = hb;
        expQ.push_back('{tag, {eJe, eJa, eSt, eFl}});
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkCounters(input string tag, input logic [CntW-1:0] eJump,
                                 input logic [CntW-1:0] eStall, input logic eTimeout);
        checks++;
        assert (jumpCnt === eJump) else begin
            errors++;
            $error("[TB] FAIL %s_jump_cnt observed=%0d expected=%0d", tag, jumpCnt, eJump);
        end
        checks++;
        assert (stallCnt === eStall) else begin
            errors++;
            $error("[TB] FAIL %s_stall_cnt observed=%0d expected=%0d", tag, stallCnt, eStall);
        end
        checks++;
        assert (holdTimeout === eTimeout) else begin
            errors++;
            $error("[TB] FAIL %s_timeout observed=%0b expected=%0b", tag, holdTimeout, eTimeout);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.jump_en_i   = 1'b0;
        bus.jump_addr_i = 32'h0;
        bus.hold_ex_i   = 1'b0;
        bus.hold_bus_i  = 1'b0;

        applyStimulus("rst0", 1, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        applyStimulus("rst1", 1, 1, 32'h44, 1, 1, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("rst", 0, 0, 0);

        // Reset while a jump is parked in HOLD_JMP must drop it.
        applyStimulus("t1_capture", 0, 1, 32'h80, 0, 1, 0, 32'h0, 3'b111, 2'b00);
        applyStimulus("t1_holdjmp", 0, 0, 32'h0, 0, 1, 0, 32'h0, 3'b111, 2'b00);
        applyStimulus("t1_rst", 1, 0, 32'h0, 0, 1, 0, 32'h0, 3'b000, 2'b00);
        applyStimulus("t1_release", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t1", 0, 0, 0);

        applyStimulus("t2_jump", 0, 1, 32'h40, 1, 0, 1, 32'h40, 3'b000, 2'b11);
        applyStimulus("t2_flush1", 0, 1, 32'h999, 0, 0, 0, 32'h0, 3'b000, 2'b11);
        applyStimulus("t2_flush2_bus", 0, 0, 32'h0, 0, 1, 0, 32'h0, 3'b100, 2'b11);
        applyStimulus("t2_run", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t2", 1, 1, 0);

        applyStimulus("t3_rst", 1, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        applyStimulus("t3_cap100", 0, 1, 32'h100, 0, 1, 0, 32'h0, 3'b111, 2'b00);
        applyStimulus("t3_ign200", 0, 1, 32'h200, 0, 1, 0, 32'h0, 3'b111, 2'b00);
        applyStimulus("t3_hold3", 0, 0, 32'h0, 0, 1, 0, 32'h0, 3'b111, 2'b00);
        applyStimulus("t3_hold4", 0, 0, 32'h0, 1, 1, 0, 32'h0, 3'b111, 2'b00);
        applyStimulus("t3_redirect", 0, 0, 32'h0, 1, 0, 1, 32'h100, 3'b000, 2'b11);
        applyStimulus("t3_flush1", 0, 1, 32'h300, 0, 0, 0, 32'h0, 3'b000, 2'b11);
        applyStimulus("t3_flush2", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b11);
        applyStimulus("t3_run", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t3", 1, 4, 0);

        for (int k = 0; k < 5; k++) begin
            applyStimulus("t4_hold_ex", 0, 0, 32'h0, 1, 0, 0, 32'h0, 3'b110, 2'b01);
        end
        applyStimulus("t4_run", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t4", 1, 9, 0);

        applyStimulus("t5_rst", 1, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        applyStimulus("t5_idle", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t5_start", 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus("t5_hold_ex", 0, 0, 32'h0, 1, 0, 0, 32'h0, 3'b110, 2'b01);
            checkCounters("t5_hold", 0, CntW'(k - 1), (k >= 9));
        end
        applyStimulus("t5_drop1", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t5_drop1", 0, 10, 1);
        applyStimulus("t5_drop2", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t5_drop2", 0, 10, 1);

        applyStimulus("t6_rst", 1, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] addr;
            addr = 32'h1000 + 32'(i * 4);
            applyStimulus("t6_jump", 0, 1, addr, 0, 0, 1, addr, 3'b000, 2'b11);
            checkCounters("t6_sat", (i > 15) ? 4'hF : CntW'(i), 0, 0);
            applyStimulus("t6_flush1", 0, 1, 32'hDEAD, 0, 0, 0, 32'h0, 3'b000, 2'b11);
            applyStimulus("t6_flush2", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b11);
        end
        applyStimulus("t6_run", 0, 0, 32'h0, 0, 0, 0, 32'h0, 3'b000, 2'b00);
        checkCounters("t6_final", 4'hF, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
